// File: rtl/message_builder.sv
// message_builder
//   Builds the 32-character ASCII frame shown by the display block. On an
//   accepted start the four channel readings are snapshotted (saturated to
//   MAX_VAL), each is converted to four BCD digits with a bit-serial
//   double-dabble, formatted into a shadow buffer, and the whole frame is
//   then published in one cycle together with a done pulse.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-low reset
//   start        frame request, sampled only while idle
//   val_ns..we   unsigned channel readings (VAL_W bits)
//   busy         high from the cycle after acceptance until done
//   done         one-cycle pulse, coincident with the message_out update
//   message_out  256-bit ASCII frame, byte n = bits [8n+7:8n]
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | load channel value into shift register, clear BCD
// SHIFT   | VAL_W double-dabble iterations
// WRITE   | store 8 formatted bytes of the channel in the shadow buffer
// PUBLISH | copy shadow to message_out, pulse done

module message_builder #(
    parameter int VAL_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] val_ns,
    input  logic [VAL_W-1:0] val_sn,
    input  logic [VAL_W-1:0] val_ew,
    input  logic [VAL_W-1:0] val_we,
    output logic             busy,
    output logic             done,
    output logic [255:0]     message_out
);

    localparam int CNT_W = $clog2(VAL_W);
    localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VAL_W - 1);
    localparam logic [255:0]     SPACES   = {32{8'h20}};

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WRITE, PUBLISH} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         ch_idx;
    logic [CNT_W-1:0]   bit_cnt;
    logic [VAL_W-1:0]   snap [4];
    logic [VAL_W-1:0]   bin;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic [255:0]       shadow;
    logic [63:0]        chan_word;
    logic [15:0]        label;

    function automatic logic [VAL_W-1:0] sat(input logic [VAL_W-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_nxt = WRITE;
            WRITE:   state_nxt = (ch_idx == 2'd3) ? PUBLISH : LOAD;
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // add-3 correction applied before every shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // label stored second-char-high so byte b+0 holds the first letter
    always_comb begin
        label = "SN";
        case (ch_idx)
            2'd0: label = "SN";
            2'd1: label = "NS";
            2'd2: label = "WE";
            2'd3: label = "EW";
            default: label = "SN";
        endcase
        chan_word = {8'h20,
                     8'd48 + {4'h0, bcd[3:0]},
                     8'd48 + {4'h0, bcd[7:4]},
                     8'd48 + {4'h0, bcd[11:8]},
                     8'd48 + {4'h0, bcd[15:12]},
                     8'h3a,
                     label};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            message_out <= SPACES;
            shadow      <= SPACES;
            ch_idx      <= 2'd0;
            bit_cnt     <= '0;
            bin         <= '0;
            bcd         <= '0;
            for (int i = 0; i < 4; i++) snap[i] <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap[0] <= sat(val_ns);
                        snap[1] <= sat(val_sn);
                        snap[2] <= sat(val_ew);
                        snap[3] <= sat(val_we);
                        ch_idx  <= 2'd0;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    bin     <= snap[ch_idx];
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    bit_cnt    <= bit_cnt + 1'b1;
                end
                WRITE: begin
                    shadow[{ch_idx, 6'd0} +: 64] <= chan_word;
                    ch_idx <= ch_idx + 2'd1;
                end
                PUBLISH: begin
                    message_out <= shadow;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_message_builder.sv
// Directed bench for message_builder. Expected frames and their due cycle
// are queued when a start is driven and compared when done appears.

module tb_message_builder;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [13:0]  val_ns = '0, val_sn = '0, val_ew = '0, val_we = '0;
    logic         busy, done;
    logic [255:0] message_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [255:0] frame;
        int           due;
    } exp_t;
    exp_t sb[$];

    logic [255:0] spaces = {32{8'h20}};

    message_builder dut (
        .clock(clock), .reset(reset), .start(start),
        .val_ns(val_ns), .val_sn(val_sn), .val_ew(val_ew), .val_we(val_we),
        .busy(busy), .done(done), .message_out(message_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model(input int ns, input int sn, input int ew, input int we);
        logic [255:0] f;
        logic [7:0]   l0 [4];
        logic [7:0]   l1 [4];
        int           v [4];
        int           x;
        l0[0] = "N"; l1[0] = "S";
        l0[1] = "S"; l1[1] = "N";
        l0[2] = "E"; l1[2] = "W";
        l0[3] = "W"; l1[3] = "E";
        v[0] = ns; v[1] = sn; v[2] = ew; v[3] = we;
        f = '0;
        for (int k = 0; k < 4; k++) begin
            x = (v[k] > 9999) ? 9999 : v[k];
            f[64*k +: 8]      = l0[k];
            f[64*k + 8 +: 8]  = l1[k];
            f[64*k + 16 +: 8] = ":";
            f[64*k + 24 +: 8] = 8'(48 + x / 1000);
            f[64*k + 32 +: 8] = 8'(48 + (x / 100) % 10);
            f[64*k + 40 +: 8] = 8'(48 + (x / 10) % 10);
            f[64*k + 48 +: 8] = 8'(48 + x % 10);
            f[64*k + 56 +: 8] = 8'h20;
        end
        return f;
    endfunction

    // scoreboard consumer
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_done cycle=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_latency", 256'(cyc), 256'(e.due));
                check("frame", message_out, e.frame);
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            checks++;
            failures++;
            $error("FAIL done_timeout cycle=%0d due=%0d", cyc, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_vals(input int ns, input int sn, input int ew, input int we);
        val_ns = 14'(ns); val_sn = 14'(sn); val_ew = 14'(ew); val_we = 14'(we);
    endtask

    // drive one start pulse and queue its expected frame
    task automatic kick(input int ns, input int sn, input int ew, input int we);
        exp_t e;
        set_vals(ns, sn, ew, we);
        start = 1'b1;
        e.frame = model(ns, sn, ew, we);
        e.due   = cyc + 1 + 65;
        sb.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input int ns, input int sn, input int ew, input int we);
        kick(ns, sn, ew, we);
        for (int i = 0; i < 65; i++) begin
            check("busy_during", 256'(busy), 256'(1));
            check("no_early_done", 256'(done), 256'(0));
            tick();
        end
        check("busy_at_done", 256'(busy), 256'(0));
        check("done_pulse", 256'(done), 256'(1));
        tick();
        check("done_single", 256'(done), 256'(0));
    endtask

    initial begin
        int c0;
        // reset
        reset = 1'b0;
        repeat (3) tick();
        check("rst_msg", message_out, spaces);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        reset = 1'b1;
        tick();
        check("post_rst_msg", message_out, spaces);
        check("post_rst_busy", 256'(busy), 256'(0));

        // nominal frame
        run_frame(9831, 4297, 1245, 2321);
        check("byte3", 256'(message_out[31:24]), 256'("9"));
        check("byte11", 256'(message_out[95:88]), 256'("4"));
        check("byte31", 256'(message_out[255:248]), 256'(8'h20));

        // saturation and zero
        run_frame(12000, 0, 9999, 10000);
        check("sat_ns", 256'(message_out[55:24]), 256'("9999"));
        check("zero_sn", 256'(message_out[119:88]), 256'("0000"));

        // inputs and start changing mid-frame are ignored
        kick(1, 22, 333, 4444);
        repeat (19) tick();
        set_vals(8765, 5678, 1111, 2222);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_vals(0, 0, 0, 0);
        repeat (60) tick();
        check("stable_queue_empty", 256'(sb.size()), 256'(0));

        // reset in the middle of a frame
        kick(7777, 6666, 5555, 4444);
        repeat (29) tick();
        reset = 1'b0;
        sb.delete();
        tick();
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_msg", message_out, spaces);
        check("midrst_done", 256'(done), 256'(0));
        reset = 1'b1;
        tick();
        run_frame(5, 60, 700, 8000);

        // back-to-back with start held high
        set_vals(3141, 5926, 5358, 9793);
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.frame = model(3141, 5926, 5358, 9793);
            e.due   = c0 + 1 + 65 + 66 * k;
            sb.push_back(e);
        end
        start = 1'b1;
        repeat (190) tick();
        start = 1'b0;
        repeat (20) tick();
        check("b2b_queue_empty", 256'(sb.size()), 256'(0));
        check("b2b_idle", 256'(busy), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/message_builder.md
Name: message_builder

Overview:
- Producer side of the 256-bit `message_in` bus consumed by `display`.
- Captures four binary readings (channels NS, SN, EW, WE) and converts each to 4-digit BCD with a sequential double-dabble.
- Formats the result into the 32-character ASCII frame that `display` renders.
- Publishes the frame atomically with a one-cycle `done` pulse.

Parameters:
- VAL_W, 14, width of each binary input value.
- MAX_VAL, 9999, saturation limit; larger inputs are displayed as MAX_VAL.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request a new frame; sampled only in IDLE.
- val_ns  input  VAL_W  channel 0 value, unsigned.
- val_sn  input  VAL_W  channel 1 value, unsigned.
- val_ew  input  VAL_W  channel 2 value, unsigned.
- val_we  input  VAL_W  channel 3 value, unsigned.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; message_out updated in the same cycle.
- message_out  output  256  ASCII frame; drives display.message_in.

Behaviour:
- Frame layout, channel k = 0..3 (NS, SN, EW, WE), base byte b = 8k, byte n = bits [8n+7:8n]:
  - b+0 / b+1: label. NS → "N","S"; SN → "S","N"; EW → "E","W"; WE → "W","E".
  - b+2: ":".
  - b+3..b+6: thousands, hundreds, tens, units, each as digit + 8'd48.
  - b+7: " " (0x20).
- Reset (reset==0 at a clock edge):
  - message_out = all bytes 0x20; busy = 0; done = 0; FSM = IDLE.
  - Applies from any state. An in-progress frame is discarded and the shadow buffer is cleared.
- Start: in IDLE, an edge with start==1 accepts the request.
  - All four inputs are snapshotted; each is saturated to MAX_VAL if greater.
  - busy = 1 next cycle.
  - Input changes after acceptance have no effect on the frame.
  - start while busy is ignored, not queued.
- FSM states: IDLE → LOAD → SHIFT → WRITE → (LOAD for next channel | PUBLISH) → IDLE.
  - LOAD (1 cycle): load the channel value into the shift register; clear the 16-bit BCD register.
  - SHIFT (VAL_W cycles): each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. A bit counter runs 0..VAL_W-1.
  - WRITE (1 cycle): write the 8 channel bytes into the shadow buffer; advance the channel index; if the index was 3, go to PUBLISH.
  - PUBLISH (1 cycle): message_out ← shadow; done = 1; busy = 0 at the same edge; return to IDLE.
- Latency: done is high in the cycle starting 4·(VAL_W+2)+1 edges after the accepting edge (65 for VAL_W = 14).
  - start may be reasserted in the cycle after done; back-to-back frames therefore have a 66-cycle period.
- message_out changes only at PUBLISH or reset; it is never partially updated.
- Arithmetic: saturation compares at full VAL_W width. BCD nibbles are always 0..9, so ASCII output is always in 0x30..0x39.

Test Plan:
- Reset held low 3 cycles, then released → message_out == 256 bits of repeated 0x20; busy = 0; done = 0.
- Single start pulse with val_ns=9831, val_sn=4297, val_ew=1245, val_we=2321 → frame reads "NS:9831 SN:4297 EW:1245 WE:2321 " in byte order 0..31. Check message_out[31:24]=="9", [95:88]=="4", [255:248]==" ".
  - done pulses exactly once, 65 cycles after the accepting edge.
  - busy is high for those 64 intervening cycles.
- Saturation and zero: val_ns=12000, val_sn=0, val_ew=9999, val_we=10000 → digits "9999", "0000", "9999", "9999".
- Input stability: change all vals and pulse start again at cycle 20 of a frame → start ignored; frame shows original snapshot; only one done.
- Reset mid-operation: assert reset at cycle 30 of a frame → next cycle busy = 0 and message_out is all spaces. After release, a new start completes normally in 65 cycles.
- Back-to-back: start held high continuously with fixed vals → done every 66 cycles; frame contents identical each time.
